// File: rtl/sort_10_unloader.sv
// sort_10_unloader: captures the 10-word parallel result of a sorter and
// replays it as a serial word stream with a valid/ready handshake. It also
// flags vectors that are not in ascending order and counts them.
module sort_10_unloader #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sort_0,
   input  logic [WIDTH-1:0] sort_1,
   input  logic [WIDTH-1:0] sort_2,
   input  logic [WIDTH-1:0] sort_3,
   input  logic [WIDTH-1:0] sort_4,
   input  logic [WIDTH-1:0] sort_5,
   input  logic [WIDTH-1:0] sort_6,
   input  logic [WIDTH-1:0] sort_7,
   input  logic [WIDTH-1:0] sort_8,
   input  logic [WIDTH-1:0] sort_9,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       out_index,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             vec_err,
   output logic [7:0]       err_count
);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'd9;

   state_t           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic             err_q, err_d;
   logic [7:0]       err_count_q, err_count_d;
   logic [WIDTH-1:0] buf_q [10];
   logic [WIDTH-1:0] in_vec [10];
   logic             desc_found;
   logic             in_xfer;
   logic             out_xfer;

   // Gather the individual sorter ports into an array for uniform indexing.
   always_comb begin
      in_vec[0] = sort_0;
      in_vec[1] = sort_1;
      in_vec[2] = sort_2;
      in_vec[3] = sort_3;
      in_vec[4] = sort_4;
      in_vec[5] = sort_5;
      in_vec[6] = sort_6;
      in_vec[7] = sort_7;
      in_vec[8] = sort_8;
      in_vec[9] = sort_9;
   end

   // Any strictly descending adjacent pair marks the incoming vector as bad.
   always_comb begin
      desc_found = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (in_vec[k] > in_vec[k+1]) begin
            desc_found = 1'b1;
         end
      end
   end

   // Handshake decode; accepting on the final word lets vectors run back-to-back.
   always_comb begin
      in_ready  = (state_q == IDLE) ||
                  ((idx_q == LAST_IDX) && out_ready);
      out_valid = (state_q == STREAM);
      in_xfer   = in_valid && in_ready;
      out_xfer  = out_valid && out_ready;
      out_index = idx_q;
      out_last  = out_valid && (idx_q == LAST_IDX);
      vec_err   = err_q;
      err_count = err_count_q;
      out_data  = '0;
      if (idx_q <= LAST_IDX) begin
         out_data = buf_q[idx_q];
      end
   end

   // Next-state logic: a new capture wins over stepping through the buffer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      err_d       = err_q;
      err_count_d = err_count_q;
      if (in_xfer) begin
         state_d = STREAM;
         idx_d   = 4'd0;
         err_d   = desc_found;
         if (desc_found && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
         end
      end else if (out_xfer) begin
         if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = 4'd0;
         end else begin
            idx_d = idx_q + 4'd1;
         end
      end
   end

   // Control state register with synchronous reset that abandons any vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= 4'd0;
         err_q       <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   // Data buffer loads on capture only; its contents are irrelevant until then.
   always_ff @(posedge clk) begin
      if (in_xfer && !rst) begin
         for (int k = 0; k < 10; k++) begin
            buf_q[k] <= in_vec[k];
         end
      end
   end

endmodule

// File: tb/tb_sort_10_unloader.sv
// tb_sort_10_unloader: directed bench for the sorter unloader.
module tb_sort_10_unloader;

   typedef logic [31:0] vec_t [10];

   logic        clk;
   logic        rst;
   logic [31:0] sort_in [10];
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_index;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        vec_err;
   logic [7:0]  err_count;

   int checks;
   int errors;

   sort_10_unloader #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .sort_0    (sort_in[0]),
      .sort_1    (sort_in[1]),
      .sort_2    (sort_in[2]),
      .sort_3    (sort_in[3]),
      .sort_4    (sort_in[4]),
      .sort_5    (sort_in[5]),
      .sort_6    (sort_in[6]),
      .sort_7    (sort_in[7]),
      .sort_8    (sort_in[8]),
      .sort_9    (sort_in[9]),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .vec_err   (vec_err),
      .err_count (err_count)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // Present a vector and wait (bounded) until it is accepted.
   task automatic applyStimulus(input vec_t v);
      int n;
      sort_in  = v;
      in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 20) begin
         stepClk();
         n++;
      end
      if (!in_ready) begin
         checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
      end
      stepClk();
      in_valid = 1'b0;
   endtask

   // Check one emitted word against the expected vector position.
   task automatic checkWord(input vec_t v, input int i, input logic err, input logic [7:0] cnt);
      checkOutput($sformatf("valid[%0d]", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("data[%0d]", i), out_data, v[i]);
      checkOutput($sformatf("index[%0d]", i), {28'd0, out_index}, i);
      checkOutput($sformatf("last[%0d]", i), {31'd0, out_last}, (i == 9) ? 32'd1 : 32'd0);
      checkOutput($sformatf("vec_err[%0d]", i), {31'd0, vec_err}, {31'd0, err});
      checkOutput($sformatf("err_count[%0d]", i), {24'd0, err_count}, {24'd0, cnt});
   endtask

   task automatic streamCheck(input vec_t v, input int from, input logic err, input logic [7:0] cnt);
      for (int i = from; i < 10; i++) begin
         checkWord(v, i, err, cnt);
         stepClk();
      end
   endtask

   initial begin
      vec_t va, vb, vc, vd, ve, vf, vg, vh;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) sort_in[k] = '0;
      for (int k = 0; k < 10; k++) begin
         va[k] = 32'(k + 1);
         vc[k] = 32'd7;
         vd[k] = 32'(100 + k);
         ve[k] = 32'(200 + k);
         vf[k] = 32'(20 + k);
         vh[k] = 32'(40 + k);
         vg[k] = 32'(10 - k);
      end
      vb = '{32'd5, 32'd3, 32'd7, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12, 32'd13};

      stepClk();
      stepClk();
      rst = 1'b0;
      #1;
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);
      checkOutput("rst_vec_err", {31'd0, vec_err}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Ascending vector streams cleanly, then block returns to idle.
      applyStimulus(va);
      streamCheck(va, 0, 1'b0, 8'd0);
      checkOutput("idle_after_a", {31'd0, out_valid}, 32'd0);

      // Descending pair flags the vector; equal words do not.
      applyStimulus(vb);
      streamCheck(vb, 0, 1'b1, 8'd1);
      applyStimulus(vc);
      streamCheck(vc, 0, 1'b0, 8'd1);

      // Back-to-back vectors with no gap cycle.
      applyStimulus(vd);
      for (int i = 0; i < 10; i++) begin
         if (i == 9) begin
            sort_in  = ve;
            in_valid = 1'b1;
            #1;
            checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
         end
         checkWord(vd, i, 1'b0, 8'd1);
         stepClk();
      end
      in_valid = 1'b0;
      streamCheck(ve, 0, 1'b0, 8'd1);
      checkOutput("idle_after_b2b", {31'd0, out_valid}, 32'd0);

      // Stall downstream for three cycles at index 4.
      applyStimulus(vf);
      streamCheck_partial: for (int i = 0; i < 4; i++) begin
         checkWord(vf, i, 1'b0, 8'd1);
         stepClk();
      end
      out_ready = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         checkOutput("stall_data", out_data, 32'd24);
         checkOutput("stall_index", {28'd0, out_index}, 32'd4);
         checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
         stepClk();
      end
      out_ready = 1'b1;
      #1;
      streamCheck(vf, 4, 1'b0, 8'd1);

      // Reset mid-vector while a new vector is offered.
      applyStimulus(vb);
      for (int i = 0; i < 6; i++) begin
         checkWord(vb, i, 1'b1, 8'd2);
         stepClk();
      end
      checkOutput("pre_rst_index", {28'd0, out_index}, 32'd6);
      rst      = 1'b1;
      sort_in  = vh;
      in_valid = 1'b1;
      stepClk();
      checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mid_rst_err_count", {24'd0, err_count}, 32'd0);
      rst = 1'b0;
      applyStimulus(vh);
      streamCheck(vh, 0, 1'b0, 8'd0);

      // Saturation of the error counter.
      for (int n = 1; n <= 256; n++) begin
         applyStimulus(vg);
         if (n == 1) checkOutput("sat_count_1", {24'd0, err_count}, 32'd1);
         if (n == 255) checkOutput("sat_count_255", {24'd0, err_count}, 32'd255);
         if (n == 256) checkOutput("sat_count_256", {24'd0, err_count}, 32'd255);
         for (int w = 0; w < 10; w++) stepClk();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sort_10_unloader.md
SORT_10_UNLOADER -- requirements
Module: sort_10_unloader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports sort_0..sort_9, input, WIDTH bits each: parallel result vector from the 10-input sorter, sort_0 expected smallest.
REQ-005 The block SHALL have port in_valid, input, 1 bit: sort_0..sort_9 hold a vector to transfer.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts a vector this cycle.
REQ-007 The block SHALL have port out_data, output, WIDTH bits: current serial word.
REQ-008 The block SHALL have port out_index, output, 4 bits: position 0..9 of out_data within its vector.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data, out_index, out_last and vec_err are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-011 The block SHALL have port out_last, output, 1 bit: high when out_index is 9.
REQ-012 The block SHALL have port vec_err, output, 1 bit: the current vector has at least one descending adjacent pair; held constant for all 10 words of that vector.
REQ-013 The block SHALL have port err_count, output, 8 bits: number of vectors accepted with a descending pair, saturating at 255.

Function
REQ-014 States SHALL be IDLE (buffer empty) and STREAM (buffer holds a vector; words being emitted).
REQ-015 An input transfer SHALL occur on a cycle where in_valid and in_ready are both high; an output transfer SHALL occur on a cycle where out_valid and out_ready are both high.
REQ-016 in_ready SHALL be high in IDLE, and in STREAM only when out_index==9 and out_ready==1 (combinational; allows back-to-back vectors); otherwise low.
REQ-017 On an input transfer, all 10 words SHALL be captured into an internal buffer, out_index SHALL be set to 0, the state SHALL become STREAM, and out_valid SHALL be high from the next cycle.
REQ-018 In STREAM, out_valid SHALL be 1 and out_data SHALL equal buffer word [out_index]; in IDLE, out_valid SHALL be 0.
REQ-019 While out_valid is high and out_ready is low, out_data, out_index, out_last and vec_err SHALL hold unchanged.
REQ-020 An output transfer with out_index<9 SHALL increment out_index by 1.
REQ-021 An output transfer with out_index==9 SHALL go to IDLE, or stay in STREAM with out_index=0 and a new buffer if an input transfer occurs in the same cycle.
REQ-022 At capture, the block SHALL evaluate sort_k > sort_(k+1) (unsigned) for k=0..8 and register the OR of the nine results as vec_err for that vector; equal words SHALL NOT count as an error.
REQ-023 err_count SHALL increment by 1 in the cycle after capture of a vector whose vec_err is 1, and SHALL hold at 255 once reached.
REQ-024 Minimum latency from input transfer to first output word SHALL be 1 cycle; sustained throughput SHALL be one vector per 10 cycles with out_ready tied high.
REQ-025 in_valid high with in_ready low SHALL have no effect; the upstream source holds the vector.

Reset
REQ-026 With rst high at a rising edge, the next state SHALL be IDLE, out_index=0, out_valid=0, vec_err=0 and err_count=0; in_ready SHALL be 1 from the following cycle.
REQ-027 rst SHALL take priority over any simultaneous transfer; a partially emitted vector SHALL be discarded and not resumed.
REQ-028 Buffer contents need no reset; out_data SHALL be don't-care while out_valid is 0.

Verification
REQ-029 Vector 1..10 is presented with out_ready=1 -> out_data 1,2,...,10 on 10 consecutive cycles; out_index is 0..9; out_last is high only on 10; vec_err=0; err_count=0.
REQ-030 Vector 5,3,7,7,8,9,10,11,12,13 is presented -> vec_err=1 on all 10 words and err_count=1; vector 7,7,...,7 is then presented -> vec_err=0 and err_count stays 1.
REQ-031 Two vectors are presented back-to-back with out_ready=1 -> in_ready is high on the cycle of word 9 of the first vector, and 20 words are emitted with no gap cycle.
REQ-032 out_ready is held low for 3 cycles at out_index=4 -> out_data and out_index stay constant, in_ready=0, and the sequence resumes at index 4 with no loss or duplication.
REQ-033 rst is asserted at out_index=6 while in_valid is high -> out_valid=0 and err_count=0 next cycle; the first vector after release starts at out_index 0.
REQ-034 256 descending vectors are presented -> err_count reads 255 and does not wrap.
